// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - handshake bundle between a byte producer, uart_tx_fifo and the UART transmitter
//
// Signals
//   wr_valid   producer presents wr_data
//   wr_data    byte to queue
//   wr_ready   FIFO can accept a byte (not full)
//   flush      discard all queued bytes that are not yet in flight
//   tx_start   transmit request, held until tx_busy is seen
//   tx_data    byte under transmission, stable while tx_start or tx_busy
//   tx_busy    transmitter busy
//   fifo_level queued byte count, 0..DEPTH
//   idle       FIFO empty and sequencer idle
// Modports
//   slave  - the FIFO side (uart_tx_fifo)
//   master - the environment side (producer plus transmitter)

interface uart_tx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              flush;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic [LVL_W-1:0]  fifo_level;
  logic              idle;

  modport slave (
    input  wr_valid, wr_data, flush, tx_busy,
    output wr_ready, tx_start, tx_data, fifo_level, idle
  );

  modport master (
    output wr_valid, wr_data, flush, tx_busy,
    input  wr_ready, tx_start, tx_data, fifo_level, idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and start/busy sequencer feeding a UART transmitter
//
// Purpose
//   Queues bytes from a valid/ready producer in a circular buffer and hands
//   them one at a time to the transmitter through a held tx_start request,
//   paced by tx_busy, so producers can burst without tracking the transmitter.
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   DATA_W  byte width
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        uart_tx_fifo_if.slave: wr_valid/wr_data/wr_ready, flush,
//              tx_start/tx_data/tx_busy, fifo_level, idle
//   ovf_count  (only with UART_TX_FIFO_OVF_CNT_EN) saturating count of
//              writes attempted while full
// Build option
//   UART_TX_FIFO_OVF_CNT_EN  adds the ovf_count output and its counter

module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_fifo_if.slave bus
`ifdef UART_TX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra bit so full and empty differ only in the MSB;
  // both wrap naturally modulo 2*DEPTH.
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] tx_data_q;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flush beats a same-cycle write; wr_ready comes from registered pointers,
  // so a write in the cycle a full FIFO pops is still refused.
  assign push = bus.wr_valid && !full && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // tx_start is held through START rather than pulsed because the
  // transmitter may only look at it on its baud tick.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (bus.tx_busy) begin
          state_nx = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // The popped byte is latched so tx_data stays stable for the whole
  // transfer, even if a flush or further writes move the pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q <= '0;
    end else if (pop) begin
      tx_data_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign bus.wr_ready   = !full;
  assign bus.tx_start   = (state == S_START);
  assign bus.tx_data    = tx_data_q;
  assign bus.fifo_level = level;
  assign bus.idle       = empty && (state == S_IDLE);

`ifdef UART_TX_FIFO_OVF_CNT_EN
  // Counts refused writes, flush cycles included; cleared by reset only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= 8'h00;
    end else if (bus.wr_valid && full && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus)
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] pend_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_sent[$];
  bit         stall      = 1'b0;
  int         busy_delay = 5;
  int         busy_len   = 3;
  int         start_cnt;
  int         busy_cnt;
  bit         last_acc;
  int         ovf_exp    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: after seeing tx_start for busy_delay samples it takes
  // the byte, raises busy, and holds it busy_len further samples.
  initial begin
    bus.tx_busy = 1'b0;
    start_cnt   = 0;
    busy_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        bus.tx_busy = 1'b0;
        start_cnt   = 0;
        busy_cnt    = 0;
      end else if (bus.tx_busy) begin
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
        else busy_cnt--;
      end else if (bus.tx_start && !stall) begin
        if (start_cnt >= busy_delay - 1) begin
          bus.tx_busy = 1'b1;
          busy_cnt    = busy_len;
          start_cnt   = 0;
          sent_q.push_back(bus.tx_data);
        end else begin
          start_cnt++;
        end
      end else begin
        start_cnt = 0;
      end
    end
  end

  // One clock with reference-model update: queue contents follow accepted
  // writes, flushes and observed pops; level and wr_ready follow from it.
  task automatic step();
    bit         acc;
    bit         fl;
    bit         prev_start;
    logic [7:0] d;
    acc        = bus.wr_valid && bus.wr_ready && !bus.flush;
    fl         = bus.flush;
    d          = bus.wr_data;
    prev_start = bus.tx_start;
    if (bus.wr_valid && !bus.wr_ready && ovf_exp < 255) ovf_exp++;
    @(posedge clk);
    #2;
    if (bus.tx_start && !prev_start) begin
      chk("pop_nonempty", 32'(pend_q.size() > 0), 1);
      if (pend_q.size() > 0) begin
        chk("pop_data", bus.tx_data, pend_q[0]);
        void'(pend_q.pop_front());
      end
    end
    if (fl) pend_q.delete();
    if (acc) pend_q.push_back(d);
    last_acc = acc;
    chk("level", bus.fifo_level, pend_q.size());
    chk("wr_ready", bus.wr_ready, 32'(pend_q.size() < DEPTH));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("ovf_count", ovf_count, ovf_exp);
`endif
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.idle && !bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_idle_timeout", 32'(ok), 1);
  endtask

  task automatic check_sent(input string tag);
    chk({tag, "_count"}, sent_q.size(), exp_sent.size());
    for (int i = 0; i < exp_sent.size() && i < sent_q.size(); i++) begin
      chk(tag, sent_q[i], exp_sent[i]);
    end
    sent_q.delete();
    exp_sent.delete();
  endtask

  initial begin
    int hold;
    int accepted;
    bit found;

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.flush    = 1'b0;
    reset_n      = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_idle", bus.idle, 1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("rst_ovf", ovf_count, 0);
`endif
    #19 reset_n = 1'b1;

    // Single byte: latency, held start, fall after busy, idle afterwards.
    push(8'hA5);
    chk("t1_start_lat1", bus.tx_start, 0);
    chk("t1_idle_busy", bus.idle, 0);
    step();
    chk("t1_start_lat2", bus.tx_start, 1);
    chk("t1_data", bus.tx_data, 8'hA5);
    hold = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bus.tx_start) break;
      hold++;
    end
    chk("t1_hold", hold, busy_delay);
    chk("t1_busy_at_fall", bus.tx_busy, 1);
    exp_sent.push_back(8'hA5);
    wait_idle(100);
    check_sent("t1_sent");

    // Burst of DEPTH bytes with transmitter stalled; one is already popped.
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      exp_sent.push_back(8'(i));
    end
    chk("t2_level", bus.fifo_level, DEPTH - 1);
    chk("t2_start_held", bus.tx_start, 1);
    stall = 1'b0;
    wait_idle(800);
    check_sent("t2_sent");

    // Fill completely, then hammer the full FIFO.
    stall = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      push(8'(8'h20 + i));
      exp_sent.push_back(8'(8'h20 + i));
    end
    chk("t3_full_ready", bus.wr_ready, 0);
    chk("t3_full_level", bus.fifo_level, DEPTH);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    for (int i = 0; i < 3; i++) step();
    chk("t3_level_after_ovf", bus.fifo_level, DEPTH);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("t3_ovf3", ovf_count, 3);
`endif
    for (int i = 0; i < 297; i++) step();
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("t3_ovf_sat", ovf_count, 8'hFF);
`endif
    bus.wr_valid = 1'b0;
    stall = 1'b0;
    wait_idle(1000);
    check_sent("t3_sent");

    // Flush while the first byte is in WAIT_DONE, with a colliding write.
    busy_len = 10;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    exp_sent.push_back(8'h40);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.tx_start && bus.tx_busy) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t4_reach_wait", 32'(found), 1);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    step();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    chk("t4_level_flushed", bus.fifo_level, 0);
    chk("t4_not_idle_inflight", bus.idle, 0);
    wait_idle(100);
    for (int i = 0; i < 20; i++) step();
    check_sent("t4_sent");
    busy_len = 3;

    // Continuous stream across pointer wrap with random transmitter pacing.
    busy_delay = $urandom_range(1, 4);
    busy_len   = $urandom_range(0, 3);
    accepted   = 0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 3000 && accepted < 3 * DEPTH; i++) begin
      bus.wr_data = 8'($urandom);
      step();
      if (last_acc) begin
        exp_sent.push_back(pend_q[pend_q.size() - 1]);
        accepted++;
      end
    end
    bus.wr_valid = 1'b0;
    chk("t5_accepted", accepted, 3 * DEPTH);
    wait_idle(1000);
    check_sent("t5_sent");
    busy_delay = 5;
    busy_len   = 3;

    // Asynchronous reset while a byte sits in START.
    stall = 1'b1;
    push(8'h77);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_start) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t6_reach_start", 32'(found), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_start", bus.tx_start, 0);
    chk("t6_rst_tx_data", bus.tx_data, 0);
    chk("t6_rst_level", bus.fifo_level, 0);
    chk("t6_rst_wr_ready", bus.wr_ready, 1);
    chk("t6_rst_idle", bus.idle, 1);
    pend_q.delete();
    sent_q.delete();
    ovf_exp = 0;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("t6_rst_ovf", ovf_count, 0);
`endif
    #5 reset_n = 1'b1;
    stall = 1'b0;
    push(8'h3C);
    exp_sent.push_back(8'h3C);
    wait_idle(100);
    check_sent("t6_sent");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
